// File: rtl/udp_echo_responder_pkg.sv
// Shared types and constants for the UDP echo responder.
package udp_echo_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    DROP    = 2'd3
  } state_t;

  localparam logic [15:0] UDP_HDR_BYTES       = 16'd8;
  localparam logic [15:0] DEFAULT_LISTEN_PORT = 16'd1234;
  localparam logic [7:0]  DEFAULT_TTL         = 8'd64;

  // UDP length counts the 8-byte header, so anything above it carries payload.
  function automatic logic has_payload(input logic [15:0] udp_length);
    return (udp_length > UDP_HDR_BYTES);
  endfunction

endpackage

// File: rtl/udp_echo_responder_skid_buffer.sv
// Two-entry AXI-stream skid buffer: 1-cycle latency, full throughput, registered head.
module axis_skid_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [KEEP_WIDTH-1:0] s_tkeep,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  input  logic                  s_tuser,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [KEEP_WIDTH-1:0] m_tkeep,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  m_tuser
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic                  user;
  } beat_t;

  beat_t      head_r;
  beat_t      tail_r;
  beat_t      in_beat_s;
  logic [1:0] count_r;
  logic       push_s;
  logic       pop_s;

  assign in_beat_s = '{data: s_tdata, keep: s_tkeep, last: s_tlast, user: s_tuser};
  assign s_tready  = (count_r != 2'd2);
  assign m_tvalid  = (count_r != 2'd0);
  assign push_s    = s_tvalid & s_tready;
  assign pop_s     = m_tvalid & m_tready;
  assign m_tdata   = head_r.data;
  assign m_tkeep   = head_r.keep;
  assign m_tlast   = head_r.last;
  assign m_tuser   = head_r.user;

  // Storage and occupancy; push+pop together only happens with one entry held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b11: head_r <= in_beat_s;
        2'b10: begin
          if (count_r == 2'd0) begin
            head_r <= in_beat_s;
          end else begin
            tail_r <= in_beat_s;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          head_r  <= tail_r;
          tail_r  <= '0;
          count_r <= count_r - 2'd1;
        end
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/udp_echo_responder.sv
// Echoes UDP frames sent to LISTEN_PORT back to the sender; drains and counts all others.
module udp_echo_responder
  import udp_echo_pkg::*;
#(
  parameter logic [15:0] LISTEN_PORT = DEFAULT_LISTEN_PORT,
  parameter logic [7:0]  TTL         = DEFAULT_TTL,
  parameter int          DATA_WIDTH  = 64,
  parameter int          CNT_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_udp_hdr_valid,
  output logic                    s_udp_hdr_ready,
  input  logic [31:0]             s_udp_ip_source_ip,
  input  logic [31:0]             s_udp_ip_dest_ip,
  input  logic [15:0]             s_udp_source_port,
  input  logic [15:0]             s_udp_dest_port,
  input  logic [15:0]             s_udp_length,
  input  logic [DATA_WIDTH-1:0]   s_udp_payload_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_udp_payload_axis_tkeep,
  input  logic                    s_udp_payload_axis_tvalid,
  output logic                    s_udp_payload_axis_tready,
  input  logic                    s_udp_payload_axis_tlast,
  input  logic                    s_udp_payload_axis_tuser,
  output logic                    m_udp_hdr_valid,
  input  logic                    m_udp_hdr_ready,
  output logic [5:0]              m_udp_ip_dscp,
  output logic [1:0]              m_udp_ip_ecn,
  output logic [7:0]              m_udp_ip_ttl,
  output logic [31:0]             m_udp_ip_source_ip,
  output logic [31:0]             m_udp_ip_dest_ip,
  output logic [15:0]             m_udp_source_port,
  output logic [15:0]             m_udp_dest_port,
  output logic [15:0]             m_udp_length,
  output logic [15:0]             m_udp_checksum,
  output logic [DATA_WIDTH-1:0]   m_udp_payload_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_udp_payload_axis_tkeep,
  output logic                    m_udp_payload_axis_tvalid,
  input  logic                    m_udp_payload_axis_tready,
  output logic                    m_udp_payload_axis_tlast,
  output logic                    m_udp_payload_axis_tuser,
  output logic [CNT_WIDTH-1:0]    echo_count,
  output logic [CNT_WIDTH-1:0]    drop_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_r;
  logic                 hdr_ready_r;
  logic                 hdr_valid_r;
  logic                 pay_open_r;
  logic [7:0]           ttl_r;
  logic [31:0]          src_ip_r;
  logic [31:0]          dst_ip_r;
  logic [15:0]          src_port_r;
  logic [15:0]          dst_port_r;
  logic [15:0]          length_r;
  logic [CNT_WIDTH-1:0] echo_count_r;
  logic [CNT_WIDTH-1:0] drop_count_r;
  logic                 hdr_hs_s;
  logic                 in_last_hs_s;
  logic                 out_last_hs_s;
  logic                 skid_in_valid_s;
  logic                 skid_in_ready_s;

  assign hdr_hs_s        = s_udp_hdr_valid & hdr_ready_r;
  assign skid_in_valid_s = s_udp_payload_axis_tvalid & pay_open_r;
  // pay_open_r closes once the tlast beat is in, so the skid never sees the next frame early.
  assign s_udp_payload_axis_tready = (state_r == DROP) | (pay_open_r & skid_in_ready_s);
  assign in_last_hs_s  = s_udp_payload_axis_tvalid & s_udp_payload_axis_tready & s_udp_payload_axis_tlast;
  assign out_last_hs_s = m_udp_payload_axis_tvalid & m_udp_payload_axis_tready & m_udp_payload_axis_tlast;

  assign s_udp_hdr_ready    = hdr_ready_r;
  assign m_udp_hdr_valid    = hdr_valid_r;
  assign m_udp_ip_dscp      = 6'd0;
  assign m_udp_ip_ecn       = 2'd0;
  assign m_udp_ip_ttl       = ttl_r;
  assign m_udp_ip_source_ip = src_ip_r;
  assign m_udp_ip_dest_ip   = dst_ip_r;
  assign m_udp_source_port  = src_port_r;
  assign m_udp_dest_port    = dst_port_r;
  assign m_udp_length       = length_r;
  assign m_udp_checksum     = 16'd0;
  assign echo_count         = echo_count_r;
  assign drop_count         = drop_count_r;

  // Frame-level control: header accept, reply header handoff, payload window, counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      hdr_ready_r  <= 1'b0;
      hdr_valid_r  <= 1'b0;
      pay_open_r   <= 1'b0;
      ttl_r        <= 8'd0;
      src_ip_r     <= 32'd0;
      dst_ip_r     <= 32'd0;
      src_port_r   <= 16'd0;
      dst_port_r   <= 16'd0;
      length_r     <= 16'd0;
      echo_count_r <= '0;
      drop_count_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          hdr_ready_r <= 1'b1;
          if (hdr_hs_s) begin
            if (!has_payload(s_udp_length)) begin
              drop_count_r <= drop_count_r + CNT_ONE;
            end else if (s_udp_dest_port == LISTEN_PORT) begin
              src_ip_r    <= s_udp_ip_dest_ip;
              dst_ip_r    <= s_udp_ip_source_ip;
              src_port_r  <= s_udp_dest_port;
              dst_port_r  <= s_udp_source_port;
              length_r    <= s_udp_length;
              ttl_r       <= TTL;
              hdr_valid_r <= 1'b1;
              hdr_ready_r <= 1'b0;
              state_r     <= HDR;
            end else begin
              hdr_ready_r <= 1'b0;
              state_r     <= DROP;
            end
          end
        end
        HDR: begin
          if (m_udp_hdr_ready) begin
            hdr_valid_r <= 1'b0;
            pay_open_r  <= 1'b1;
            state_r     <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (in_last_hs_s) begin
            pay_open_r <= 1'b0;
          end
          if (out_last_hs_s) begin
            echo_count_r <= echo_count_r + CNT_ONE;
            hdr_ready_r  <= 1'b1;
            state_r      <= IDLE;
          end
        end
        DROP: begin
          if (in_last_hs_s) begin
            drop_count_r <= drop_count_r + CNT_ONE;
            hdr_ready_r  <= 1'b1;
            state_r      <= IDLE;
          end
        end
        default: begin
          hdr_valid_r <= 1'b0;
          pay_open_r  <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  axis_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tdata  (s_udp_payload_axis_tdata),
    .s_tkeep  (s_udp_payload_axis_tkeep),
    .s_tvalid (skid_in_valid_s),
    .s_tready (skid_in_ready_s),
    .s_tlast  (s_udp_payload_axis_tlast),
    .s_tuser  (s_udp_payload_axis_tuser),
    .m_tdata  (m_udp_payload_axis_tdata),
    .m_tkeep  (m_udp_payload_axis_tkeep),
    .m_tvalid (m_udp_payload_axis_tvalid),
    .m_tready (m_udp_payload_axis_tready),
    .m_tlast  (m_udp_payload_axis_tlast),
    .m_tuser  (m_udp_payload_axis_tuser)
  );

endmodule

// File: tb/tb_udp_echo_responder.sv
// Randomized self-checking bench for udp_echo_responder with a queue-based reference model.
module tb_udp_echo_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        s_udp_hdr_valid = 1'b0;
  logic        s_udp_hdr_ready;
  logic [31:0] s_udp_ip_source_ip = 32'd0;
  logic [31:0] s_udp_ip_dest_ip = 32'd0;
  logic [15:0] s_udp_source_port = 16'd0;
  logic [15:0] s_udp_dest_port = 16'd0;
  logic [15:0] s_udp_length = 16'd0;
  logic [63:0] s_tdata = 64'd0;
  logic [7:0]  s_tkeep = 8'd0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic        s_tuser = 1'b0;
  logic        m_udp_hdr_valid;
  logic        m_udp_hdr_ready;
  logic [5:0]  m_udp_ip_dscp;
  logic [1:0]  m_udp_ip_ecn;
  logic [7:0]  m_udp_ip_ttl;
  logic [31:0] m_udp_ip_source_ip;
  logic [31:0] m_udp_ip_dest_ip;
  logic [15:0] m_udp_source_port;
  logic [15:0] m_udp_dest_port;
  logic [15:0] m_udp_length;
  logic [15:0] m_udp_checksum;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        m_tuser;
  logic [15:0] echo_count;
  logic [15:0] drop_count;

  always #5 clk = ~clk;

  udp_echo_responder dut (
    .clk(clk), .rst_n(rst_n),
    .s_udp_hdr_valid(s_udp_hdr_valid), .s_udp_hdr_ready(s_udp_hdr_ready),
    .s_udp_ip_source_ip(s_udp_ip_source_ip), .s_udp_ip_dest_ip(s_udp_ip_dest_ip),
    .s_udp_source_port(s_udp_source_port), .s_udp_dest_port(s_udp_dest_port),
    .s_udp_length(s_udp_length),
    .s_udp_payload_axis_tdata(s_tdata), .s_udp_payload_axis_tkeep(s_tkeep),
    .s_udp_payload_axis_tvalid(s_tvalid), .s_udp_payload_axis_tready(s_tready),
    .s_udp_payload_axis_tlast(s_tlast), .s_udp_payload_axis_tuser(s_tuser),
    .m_udp_hdr_valid(m_udp_hdr_valid), .m_udp_hdr_ready(m_udp_hdr_ready),
    .m_udp_ip_dscp(m_udp_ip_dscp), .m_udp_ip_ecn(m_udp_ip_ecn), .m_udp_ip_ttl(m_udp_ip_ttl),
    .m_udp_ip_source_ip(m_udp_ip_source_ip), .m_udp_ip_dest_ip(m_udp_ip_dest_ip),
    .m_udp_source_port(m_udp_source_port), .m_udp_dest_port(m_udp_dest_port),
    .m_udp_length(m_udp_length), .m_udp_checksum(m_udp_checksum),
    .m_udp_payload_axis_tdata(m_tdata), .m_udp_payload_axis_tkeep(m_tkeep),
    .m_udp_payload_axis_tvalid(m_tvalid), .m_udp_payload_axis_tready(m_tready),
    .m_udp_payload_axis_tlast(m_tlast), .m_udp_payload_axis_tuser(m_tuser),
    .echo_count(echo_count), .drop_count(drop_count)
  );

  typedef struct packed {
    logic [31:0] sip;
    logic [31:0] dip;
    logic [15:0] sp;
    logic [15:0] dp;
    logic [15:0] len;
  } hdr_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  hdr_t  hq[$];
  beat_t pq[$];
  hdr_t  cur_oh, last_out_hdr;
  beat_t cur_ob;
  int    checks = 0, failures = 0;
  int    exp_echo = 0, exp_drop = 0;
  bit    busy = 1'b0, pay_open = 1'b0, drop_open = 1'b0, live = 1'b0;
  int    stall_cnt = 0, user_last_cnt = 0, keep0f_cnt = 0;
  int    m_mode = 0, hold_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: a reply header per accepted echo header, payload FIFO ordering, counters.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_hdr_valid", m_udp_hdr_valid, 0);
      chk("rst_hdr_ready", s_udp_hdr_ready, 0);
      chk("rst_s_tready", s_tready, 0);
      chk("rst_m_tvalid", {m_tvalid, m_tlast, m_tuser}, 0);
      chk("rst_counts", {echo_count, drop_count}, 0);
      hq.delete(); pq.delete();
      exp_echo = 0; exp_drop = 0;
      busy = 0; pay_open = 0; drop_open = 0; live = 0;
    end else begin
      cur_oh = hdr_t'{m_udp_ip_source_ip, m_udp_ip_dest_ip, m_udp_source_port, m_udp_dest_port, m_udp_length};
      cur_ob = beat_t'{m_tdata, m_tkeep, m_tlast, m_tuser};
      chk("hdr_valid", m_udp_hdr_valid, hq.size() > 0);
      if (m_udp_hdr_valid && hq.size() > 0) begin
        chk("hdr_fields", cur_oh, hq[0]);
        chk("hdr_ttl", m_udp_ip_ttl, 8'd64);
        chk("hdr_const", {m_udp_ip_dscp, m_udp_ip_ecn, m_udp_checksum}, 0);
      end
      chk("pay_valid", m_tvalid, pq.size() > 0);
      if (m_tvalid && pq.size() > 0) chk("pay_beat", cur_ob, pq[0]);
      if (live) chk("hdr_ready", s_udp_hdr_ready, !busy);
      chk("s_tready", s_tready, drop_open ? 1 : (pay_open ? (pq.size() < 2) : 0));
      chk("echo_count", echo_count, 16'(exp_echo));
      chk("drop_count", drop_count, 16'(exp_drop));

      if (m_udp_hdr_valid && !m_udp_hdr_ready) stall_cnt++;
      if (m_udp_hdr_valid && m_udp_hdr_ready) begin
        last_out_hdr = cur_oh;
        if (hq.size() > 0) void'(hq.pop_front());
        pay_open = 1;
      end
      if (m_tvalid && m_tready) begin
        if (pq.size() > 0) void'(pq.pop_front());
        if (m_tlast) begin
          exp_echo++; busy = 0;
          if (m_tuser) user_last_cnt++;
          if (m_tkeep == 8'h0F) keep0f_cnt++;
        end
      end
      if (s_tvalid && s_tready) begin
        if (drop_open) begin
          if (s_tlast) begin exp_drop++; drop_open = 0; busy = 0; end
        end else if (pay_open) begin
          pq.push_back(beat_t'{s_tdata, s_tkeep, s_tlast, s_tuser});
          if (s_tlast) pay_open = 0;
        end
      end
      if (s_udp_hdr_valid && s_udp_hdr_ready) begin
        if (s_udp_length <= 16'd8) exp_drop++;
        else if (s_udp_dest_port == 16'd1234) begin
          hq.push_back(hdr_t'{s_udp_ip_dest_ip, s_udp_ip_source_ip, s_udp_dest_port, s_udp_source_port, s_udp_length});
          busy = 1;
        end else begin
          drop_open = 1; busy = 1;
        end
      end
      live = 1;
    end
  end

  // Downstream sink behaviour selected by m_mode.
  initial begin
    m_udp_hdr_ready = 1'b0;
    m_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (m_mode)
        0: begin m_udp_hdr_ready = 1'b1; m_tready = 1'b1; end
        1: begin m_udp_hdr_ready = ($urandom_range(0, 3) != 0); m_tready = ($urandom_range(0, 3) != 0); end
        2: begin
          m_udp_hdr_ready = (hold_cnt >= 10);
          if (m_udp_hdr_valid) hold_cnt++;
          m_tready = !m_tready;
        end
        3: begin m_udp_hdr_ready = 1'b1; m_tready = 1'b0; end
        default: begin m_udp_hdr_ready = 1'b1; m_tready = 1'b1; end
      endcase
    end
  end

  task automatic send_hdr(input logic [31:0] sip, input logic [31:0] dip, input logic [15:0] sp,
                          input logic [15:0] dp, input logic [15:0] len);
    int n = 0;
    s_udp_ip_source_ip = sip; s_udp_ip_dest_ip = dip;
    s_udp_source_port = sp; s_udp_dest_port = dp; s_udp_length = len;
    s_udp_hdr_valid = 1'b1;
    @(negedge clk);
    while (!s_udp_hdr_ready && n < 2000) begin n++; @(negedge clk); end
    if (n >= 2000) chk("hdr_timeout", 0, 1);
    @(posedge clk); #1;
    s_udp_hdr_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u);
    int n = 0;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 2000) begin n++; @(negedge clk); end
    if (n >= 2000) chk("beat_timeout", 0, 1);
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] sip, input logic [31:0] dip, input logic [15:0] sp,
                            input logic [15:0] dp, input logic [15:0] len, input logic user, input int gap);
    int nb, rem;
    logic [7:0] k;
    send_hdr(sip, dip, sp, dp, len);
    if (len > 16'd8) begin
      nb = (int'(len) - 8 + 7) / 8;
      rem = (int'(len) - 8) % 8;
      k = 8'hFF;
      if (rem != 0) k = k >> (8 - rem);
      for (int b = 0; b < nb; b++) begin
        while ($urandom_range(0, 99) < gap) begin @(posedge clk); #1; end
        send_beat({$urandom, $urandom}, (b == nb - 1) ? k : 8'hFF, b == nb - 1, (b == nb - 1) ? user : 1'b0);
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (3) @(posedge clk);
    while ((busy || hq.size() > 0 || pq.size() > 0) && n < 5000) begin n++; @(posedge clk); end
    if (n >= 5000) chk("idle_timeout", 0, 1);
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    do_reset();

    // Directed echo: 192.168.1.10:5000 -> 192.168.1.128:1234, two full beats.
    send_frame(32'hC0A8010A, 32'hC0A80180, 16'd5000, 16'd1234, 16'd24, 1'b0, 0);
    wait_idle();
    chk("t1_src_ip", last_out_hdr.sip, 32'hC0A80180);
    chk("t1_dst_ip", last_out_hdr.dip, 32'hC0A8010A);
    chk("t1_ports", {last_out_hdr.sp, last_out_hdr.dp}, {16'd1234, 16'd5000});
    chk("t1_len", last_out_hdr.len, 16'd24);
    chk("t1_counts", {echo_count, drop_count}, {16'd1, 16'd0});

    // Non-listening port: drained, counted.
    send_frame(32'h0A000001, 32'h0A000002, 16'd4000, 16'd80, 16'd40, 1'b0, 0);
    wait_idle();
    chk("t2_counts", {echo_count, drop_count}, {16'd1, 16'd1});

    // Header stalled 10 cycles, toggling payload ready.
    m_mode = 2; hold_cnt = 0; stall_cnt = 0;
    send_frame(32'h01020304, 32'h05060708, 16'd7, 16'd1234, 16'd56, 1'b0, 0);
    wait_idle();
    chk("t3_stall", stall_cnt >= 10, 1);
    chk("t3_echo", echo_count, 16'd2);
    m_mode = 0;

    // Three back-to-back frames, partial last beat, tuser on the middle one.
    user_last_cnt = 0; keep0f_cnt = 0;
    send_frame(32'h11111111, 32'h22222222, 16'd1, 16'd1234, 16'd28, 1'b0, 0);
    send_frame(32'h33333333, 32'h44444444, 16'd2, 16'd1234, 16'd28, 1'b1, 0);
    send_frame(32'h55555555, 32'h66666666, 16'd3, 16'd1234, 16'd28, 1'b0, 0);
    wait_idle();
    chk("t4_keep0f", keep0f_cnt, 3);
    chk("t4_user", user_last_cnt, 1);
    chk("t4_echo", echo_count, 16'd5);

    // Header-only frame on the listening port.
    send_hdr(32'h77777777, 32'h88888888, 16'd9, 16'd1234, 16'd8);
    wait_idle();
    chk("t5_drop", drop_count, 16'd2);
    send_frame(32'h77777777, 32'h88888888, 16'd9, 16'd1234, 16'd17, 1'b0, 0);
    wait_idle();
    chk("t5_echo", echo_count, 16'd6);

    // Reset after the first of four beats.
    m_mode = 3;
    send_hdr(32'h99999999, 32'hAAAAAAAA, 16'd10, 16'd1234, 16'd40);
    send_beat(64'hDEADBEEFCAFEF00D, 8'hFF, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_out_zero", {m_tvalid, m_udp_hdr_valid, s_tready, s_udp_hdr_ready}, 0);
    chk("t6_counts", {echo_count, drop_count}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    m_mode = 0;
    send_frame(32'h0B0B0B0B, 32'h0C0C0C0C, 16'd11, 16'd1234, 16'd32, 1'b0, 0);
    wait_idle();
    chk("t6_echo", {echo_count, drop_count}, {16'd1, 16'd0});

    // Randomized traffic against the model.
    m_mode = 1;
    for (int f = 0; f < 40; f++) begin
      send_frame($urandom, $urandom, 16'($urandom),
                 ($urandom_range(0, 3) == 0) ? 16'(2000 + $urandom_range(0, 100)) : 16'd1234,
                 ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 8)) : 16'($urandom_range(9, 90)),
                 1'($urandom_range(0, 1)), 30);
    end
    wait_idle();
    chk("final_queues", hq.size() + pq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
